// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler.
//   - state_e : FSM state encodings (IDLE/GRANT/GAP)
//   - N_REQ_DEF, CODE_W_DEF : default requester count and grant code width
package rr_sched_pkg;
  localparam int N_REQ_DEF  = 16;
  localparam int CODE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
//   req : request vector
//   ptr : index of the last grantee; search starts at ptr+1 and wraps
//   idx : first set request at or after ptr+1 (mod N_REQ)
//   any : at least one request is set
// N_REQ must equal 2**CODE_W so index arithmetic wraps for free.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] idx,
  output logic              any
);
  logic [CODE_W-1:0] w_pos;

  // Scan farthest offset first so the nearest set bit after ptr is the last write.
  always_comb begin
    idx   = '0;
    w_pos = '0;
    any   = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = ptr + CODE_W'(k + 1);
      if (req[w_pos]) idx = w_pos;
    end
  end
endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler driving a CODE_W-to-N_REQ decoded select bus.
//   clk       : clock
//   rst       : synchronous active-high reset
//   req       : request vector, bit i = requester i wants the bus
//   gnt_code  : registered index of current/last grantee (decoder input)
//   gnt_valid : registered, high while a grant is active (gates decoder)
//   preempt   : registered one-cycle pulse when a grant is revoked by timeout
// A grant is held while its owner keeps requesting, up to MAX_HOLD cycles
// when others wait. Every release passes through one GAP cycle so two
// decoded lines are never active back to back.
module rr_grant_sched
  import rr_sched_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] gnt_code,
  output logic              gnt_valid,
  output logic              preempt
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            r_state;
  logic [CODE_W-1:0] r_ptr;
  logic [CODE_W-1:0] r_code;
  logic [HOLD_W-1:0] r_hold;
  logic              r_valid;
  logic              r_preempt;

  logic [CODE_W-1:0] w_idx;
  logic              w_any;
  logic              w_own;
  logic              w_others;
  logic              w_at_max;

  rr_pick #(.N_REQ(N_REQ), .CODE_W(CODE_W)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_own    = req[r_code];
  assign w_others = |(req & ~(N_REQ'(1) << r_code));
  assign w_at_max = (r_hold == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= CODE_W'(N_REQ - 1);
      r_code    <= '0;
      r_hold    <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          r_preempt <= 1'b0;
          if (w_any) begin
            // ptr was left at the released index, so it now ranks last.
            r_state <= GRANT;
            r_code  <= w_idx;
            r_ptr   <= w_idx;
            r_hold  <= HOLD_W'(1);
            r_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          if (!w_own) begin
            r_state <= GAP;
            r_valid <= 1'b0;
          end else if (w_at_max && w_others) begin
            r_state   <= GAP;
            r_valid   <= 1'b0;
            r_preempt <= 1'b1;
          end else if (!w_at_max) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
          // at max with no competitor: hold saturates, grant stays
        end
        default: begin
          r_state   <= IDLE;
          r_ptr     <= CODE_W'(N_REQ - 1);
          r_code    <= '0;
          r_hold    <= '0;
          r_valid   <= 1'b0;
          r_preempt <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_code  = r_code;
  assign gnt_valid = r_valid;
  assign preempt   = r_preempt;
endmodule

// File: tb/tb_rr_grant_sched.sv
module tb_rr_grant_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [3:0]  gnt_code;
  logic        gnt_valid;
  logic        preempt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       p;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   vec_id = 0;

  always #5 clk = ~clk;

  rr_grant_sched #(.N_REQ(16), .CODE_W(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_code  (gnt_code),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  // Apply one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic st(input logic r, input logic [15:0] rq,
                    input logic v, input int c, input logic p);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.v  = v;
    e.c  = 4'(c);
    e.p  = p;
    e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare shortly after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt_valid !== e.v || gnt_code !== e.c || preempt !== e.p) begin
          errors++;
          $display("FAIL vec%0d: got valid=%b code=%0d preempt=%b, want valid=%b code=%0d preempt=%b",
                   e.id, gnt_valid, gnt_code, preempt, e.v, e.c, e.p);
        end
      end
    end
  end

  initial begin
    // reset, then first grant to 0
    st(1, 16'h0001, 0, 0, 0);
    st(1, 16'h0001, 0, 0, 0);
    st(0, 16'h0001, 1, 0, 0);

    // rotation and wrap: order 0,1,15,0 with one dead cycle between grants
    st(1, 16'h0000, 0, 0, 0);
    st(0, 16'h8003, 1, 0, 0);
    st(0, 16'h8003, 1, 0, 0);
    st(0, 16'h8002, 0, 0, 0);
    st(0, 16'h8003, 1, 1, 0);
    st(0, 16'h8003, 1, 1, 0);
    st(0, 16'h8001, 0, 1, 0);
    st(0, 16'h8003, 1, 15, 0);
    st(0, 16'h8003, 1, 15, 0);
    st(0, 16'h0003, 0, 15, 0);
    st(0, 16'h8003, 1, 0, 0);
    st(0, 16'h0000, 0, 0, 0);
    st(0, 16'h0000, 0, 0, 0);

    // timeout preemption: 5 holds 8 cycles, 9 waits from cycle 3
    st(0, 16'h0020, 1, 5, 0);
    st(0, 16'h0020, 1, 5, 0);
    for (int i = 0; i < 6; i++) st(0, 16'h0220, 1, 5, 0);
    st(0, 16'h0220, 0, 5, 1);
    st(0, 16'h0220, 1, 9, 0);
    st(0, 16'h0000, 0, 9, 0);
    st(0, 16'h0000, 0, 9, 0);

    // sole requester saturation
    for (int i = 0; i < 40; i++) st(0, 16'h0008, 1, 3, 0);
    checks++;
    if (dut.r_hold !== 4'd8) begin
      errors++;
      $display("FAIL hold_sat: got hold=%0d, want 8", dut.r_hold);
    end
    st(0, 16'h0000, 0, 3, 0);
    st(0, 16'h0000, 0, 3, 0);

    // release to idle: code 7 persists with valid low
    st(0, 16'h0080, 1, 7, 0);
    st(0, 16'h0080, 1, 7, 0);
    st(0, 16'h0000, 0, 7, 0);
    st(0, 16'h0000, 0, 7, 0);
    for (int i = 0; i < 3; i++) st(0, 16'h0000, 0, 7, 0);

    // reset mid-grant, ptr restart honoured
    st(0, 16'h1000, 1, 12, 0);
    st(0, 16'h1000, 1, 12, 0);
    st(1, 16'h1000, 0, 0, 0);
    st(0, 16'h1001, 1, 0, 0);
    st(0, 16'h1001, 1, 0, 0);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
